// File: rtl/counter_1.sv
// Free-running up-counter: adds STEP every clock and wraps to RESET_VAL
// once the next value would pass MAX_VAL. rst is synchronous, active-high.
module counter_1 #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  STEP      = 1,
  parameter logic [WIDTH-1:0]  MAX_VAL   = '1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;
  logic             wrap;

  // Extra bit keeps count + STEP from overflowing before the compare.
  assign sum  = {1'b0, count_q} + {1'b0, STEP};
  assign wrap = sum > {1'b0, MAX_VAL};

  always_comb begin
    count_d = count_q;
    if (wrap) count_d = RESET_VAL;
    else      count_d = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= RESET_VAL;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter_1.sv
// Bench for counter_1: directed vector table, hand sequences for wrap/reset
// corners, and random reset traffic checked against a cyclic-sequence model.
module tb_counter_1;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_1 u_def (
    .clk   (clk),
    .rst   (rst_a),
    .count (cnt_a)
  );

  counter_1 #(
    .WIDTH     (4),
    .STEP      (4'd3),
    .MAX_VAL   (4'd10),
    .RESET_VAL (4'd1)
  ) u_ovr (
    .clk   (clk),
    .rst   (rst_b),
    .count (cnt_b)
  );

  typedef struct {
    logic rst;
    int   exp;
  } vec_t;

  // Reference: the legal values visited in order, as a cyclic list.
  int seq_a[$];
  int seq_b[$];
  int idx_a, idx_b;

  function automatic void build(ref int q[$], input int rv, input int st, input int mx);
    q.delete();
    for (int v = rv; v <= mx; v += st) q.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply rst for one rising edge, then sample 1 ns after it.
  task automatic edge_a(input logic r);
    rst_a = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_a(input int target);
    int n = 0;
    while (int'(cnt_a) != target && n < 600) begin
      edge_a(1'b0);
      n++;
    end
    chk("run_to_a", int'(cnt_a), target);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 0};
    vecs[1] = '{1'b1, 0};
    vecs[2] = '{1'b1, 0};
    vecs[3] = '{1'b0, 1};
    vecs[4] = '{1'b0, 2};
    vecs[5] = '{1'b0, 3};

    build(seq_a, 0, 1, 255);
    build(seq_b, 1, 3, 10);

    // Reset hold then first increments.
    for (int i = 0; i < 6; i++) begin
      edge_a(vecs[i].rst);
      chk($sformatf("vec%0d", i), int'(cnt_a), vecs[i].exp);
    end

    // Full lap: 0..255, wrap to 0, then 1.
    edge_a(1'b1);
    chk("lap_start", int'(cnt_a), 0);
    for (int i = 0; i < 257; i++) begin
      edge_a(1'b0);
      if (i == 254) chk("lap_max", int'(cnt_a), 255);
      else if (i == 255) chk("lap_wrap", int'(cnt_a), 0);
      else if (i == 256) chk("lap_after", int'(cnt_a), 1);
    end

    // Reset mid-count at 100.
    run_to_a(100);
    edge_a(1'b1);
    chk("mid_rst", int'(cnt_a), 0);
    edge_a(1'b0);
    chk("mid_rel", int'(cnt_a), 1);

    // Long reset: no increments.
    begin
      int bad = 0;
      for (int i = 0; i < 50; i++) begin
        edge_a(1'b1);
        if (cnt_a != 8'd0) bad++;
      end
      chk("long_rst_bad_edges", bad, 0);
      chk("long_rst_val", int'(cnt_a), 0);
    end

    // Reset on the edge that would wrap.
    edge_a(1'b0);
    run_to_a(255);
    edge_a(1'b1);
    chk("wrap_rst", int'(cnt_a), 0);
    edge_a(1'b0);
    chk("wrap_rst_rel", int'(cnt_a), 1);

    // Override instance: 1, 4, 7, 10, 1, 4.
    begin
      int exp_b[6];
      exp_b = '{1, 4, 7, 10, 1, 4};
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_rst", int'(cnt_b), exp_b[0]);
      rst_b = 1'b0;
      for (int i = 1; i < 6; i++) begin
        @(posedge clk);
        #1;
        chk($sformatf("ovr_seq%0d", i), int'(cnt_b), exp_b[i]);
      end
    end

    // Random reset traffic on both instances against the sequence model.
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    idx_a = 0;
    idx_b = 0;
    chk("rand_init_a", int'(cnt_a), seq_a[0]);
    chk("rand_init_b", int'(cnt_b), seq_b[0]);
    begin
      int bad_a = 0;
      int bad_b = 0;
      for (int i = 0; i < 2000; i++) begin
        rst_a = ($urandom_range(0, 99) == 0);
        rst_b = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        #1;
        idx_a = rst_a ? 0 : (idx_a + 1) % seq_a.size();
        idx_b = rst_b ? 0 : (idx_b + 1) % seq_b.size();
        if (int'(cnt_a) != seq_a[idx_a]) begin
          bad_a++;
          if (bad_a < 5) $display("FAIL rand_a cycle %0d: got %0d expected %0d", i, cnt_a, seq_a[idx_a]);
        end
        if (int'(cnt_b) != seq_b[idx_b]) begin
          bad_b++;
          if (bad_b < 5) $display("FAIL rand_b cycle %0d: got %0d expected %0d", i, cnt_b, seq_b[idx_b]);
        end
      end
      chk("rand_a_bad_cycles", bad_a, 0);
      chk("rand_b_bad_cycles", bad_b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_1.md
# counter_1

Free-running synchronous up-counter that supplies a WIDTH-bit count value to downstream logic on every clock cycle. It has a synchronous, active-high clear and no enable. It counts from its reset value up to a programmable terminal value and then wraps. The default configuration is an 8-bit counter running 0 → 255 → 0.

## Interface

Parameters:
- WIDTH, 8: counter and output width in bits; legal range ≥ 1.
- STEP, 1: increment added each cycle; legal range 1 ≤ STEP ≤ 2^WIDTH−1.
- MAX_VAL, 2^WIDTH−1: terminal value after which the counter wraps; legal range 0 ≤ MAX_VAL ≤ 2^WIDTH−1.
- RESET_VAL, 0: value loaded by reset and on wrap; must be ≤ MAX_VAL.

Ports (positional order clk, rst, count):
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
- count  output  WIDTH  current counter value, driven directly from a register.

## Operation

- One clock; reset is synchronous and active-high.
- Rising edge of clk with rst = 1:
  - count ← RESET_VAL.
  - Reset has priority over counting.
  - Held as long as rst stays high.
- Rising edge of clk with rst = 0:
  - If count > MAX_VAL − STEP, count ← RESET_VAL (wrap).
  - Otherwise count ← count + STEP.
- Arithmetic rules:
  - The comparison uses a WIDTH+1-bit sum, so no intermediate overflow occurs.
  - The result is never outside RESET_VAL..MAX_VAL.
- Default parameters give the sequence 0, 1, 2, …, 254, 255, 0, 1, … with natural modulo-256 wrap.
- No other inputs and no enable: the counter advances on every non-reset edge.
- count is a pure register output with no combinational path from rst or clk.
- Power-up value before the first reset edge is undefined; the X-state is not checked.

## Timing

- Reset latency: count equals RESET_VAL starting one rising edge after rst is sampled high.
- Release: the first rising edge with rst = 0 produces RESET_VAL + STEP.
- Count latency: each non-reset edge advances count exactly once. The new value is visible after the clock-to-Q delay and stays stable for the whole cycle.
- Wrap: the edge at which count = MAX_VAL (default 255) loads RESET_VAL. There is no extra cycle and no stall.
- Reset mid-count: rst asserted at any value, including MAX_VAL, forces RESET_VAL on that edge. Counting resumes from RESET_VAL + STEP on the first edge after release.
- Reset glitches between edges have no effect.
- Reference clock in the bench: 10 ns period (toggle every 5 ns).

## Test plan

- Hold rst = 1 for 3 edges, then rst = 0 -> count = 0 during reset; count = 1, 2, 3 on the following three edges.
- Run 256 consecutive non-reset edges from 0 -> count reaches 255, then reads 0 on the next edge, then 1.
- Assert rst for one edge while count = 100 -> count = 0 on that edge; count = 1 on the next edge after release.
- Keep rst = 1 continuously for 50 edges -> count remains 0 throughout, with no increments.
- Parameter override WIDTH = 4, STEP = 3, MAX_VAL = 10, RESET_VAL = 1 -> sequence after reset release is 1, 4, 7, 10, 1, 4.
- Assert rst on the same edge at which count = 255 would wrap -> count = 0, and the next non-reset edge gives 1; reset priority holds and no double update occurs.
